// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// the bit-period helper used to size the per-frame baud counter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Truncating division; a fractional remainder shows up as baud error.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Restartable bit-period counter: cleared on frame accept so every frame
// starts phase-aligned, pulses bit_tick on the last cycle of each bit.
module uart_tx_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && !clear && (cnt_q == TERMINAL);

endmodule

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, LSB first, 1 start bit, optional parity and
// 1 or 2 stop bits; all outputs are registered.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txEn,
    input  logic       start,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       txBusy,
    output logic       txDone
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       par_q;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;

    logic accept;
    logic baud_clear;
    logic baud_run;
    logic bit_tick;

    function automatic logic calc_parity(input logic [7:0] d);
        logic p;
        case (PARITY)
            PAR_EVEN: p = ^d;
            PAR_ODD:  p = ~^d;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    assign accept     = (state_q == ST_IDLE) && txEn && start;
    assign baud_clear = accept || !txEn;
    assign baud_run   = (state_q != ST_IDLE);

    uart_tx_baud_cnt #(
        .CLKS_PER_BIT(CPB)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .run     (baud_run),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!txEn) begin
            // Abort: return to idle silently, no completion pulse.
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q   <= in_data;
                        par_q     <= calc_parity(in_data);
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an 8N1 instance and an 8O2 instance, checked
// against a frame model built from the byte, plus a mid-bit sampling receiver.
module tb_uart_transmitter;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 4;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txEn = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    logic       sel = 1'b0;
    logic       tx_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] mon_d;

    always #5 clk = ~clk;

    assign tx_s   = sel ? tx2   : tx1;
    assign busy_s = sel ? busy2 : busy1;
    assign done_s = sel ? done2 : done1;

    uart_transmitter #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .txEn(txEn), .start(start1), .in_data(in_data),
        .tx(tx1), .txBusy(busy1), .txDone(done1)
    );

    uart_transmitter #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst(rst), .txEn(txEn), .start(start2), .in_data(in_data),
        .tx(tx2), .txBusy(busy2), .txDone(done2)
    );

    // Receiver on the 8N1 line: find start, then sample each bit mid-period.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx1 === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    mon_d[j] = tx1;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b, input int mode);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (mode == 1) return (ones % 2) != 0;
        if (mode == 2) return (ones % 2) == 0;
        return 1'b0;
    endfunction

    task automatic accept(input logic [7:0] b);
        if (sel) start2 = 1'b1;
        else     start1 = 1'b1;
        in_data = b;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Called in the cycle after accept; returns in the txDone cycle.
    task automatic check_frame(input logic [7:0] b, input int pmode, input int stops, input int inj);
        logic exp_bits[$];
        int   cyc = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (pmode != 0) exp_bits.push_back(model_parity(b, pmode));
        for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
        for (int k = 0; k < exp_bits.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                cyc++;
                chk($sformatf("tx_bit%0d_c%0d", k, c), tx_s, exp_bits[k]);
                chk($sformatf("busy_bit%0d_c%0d", k, c), busy_s, 1);
                chk($sformatf("done_bit%0d_c%0d", k, c), done_s, 0);
                if (inj != 0 && cyc == inj) begin
                    start1  = 1'b1;
                    in_data = 8'h3C;
                end else begin
                    start1  = 1'b0;
                    in_data = 8'($urandom);
                end
                tick();
            end
        end
        start1 = 1'b0;
        chk("done_pulse", done_s, 1);
        chk("busy_end", busy_s, 0);
        chk("tx_end", tx_s, 1);
    endtask

    task automatic check_rx(input logic [7:0] b);
        chk("rx_avail", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) chk("rx_byte", rx_q.pop_front(), b);
    endtask

    initial begin
        logic [7:0] b;
        int nd;
        int nb;

        // Asynchronous reset while start is held high
        txEn    = 1'b1;
        start1  = 1'b1;
        start2  = 1'b1;
        in_data = 8'h5A;
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_tx2", tx2, 1);
        chk("rst_busy2", busy2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_busy", busy1, 0);
            chk("rst_hold_tx", tx1, 1);
        end
        start1 = 1'b0;
        start2 = 1'b0;
        #3 rst = 1'b0;
        tick();
        tick();
        chk("post_rst_busy", busy1, 0);
        chk("post_rst_tx", tx1, 1);
        chk("post_rst_done", done1, 0);

        // Single byte 0xA5
        accept(8'hA5);
        check_frame(8'hA5, 0, 1, 0);
        check_rx(8'hA5);
        tick();
        chk("a5_done_once", done1, 0);
        chk("a5_idle_busy", busy1, 0);

        // Back-to-back: second start issued in the txDone cycle
        accept(8'h00);
        check_frame(8'h00, 0, 1, 0);
        accept(8'hFF);
        check_frame(8'hFF, 0, 1, 0);
        check_rx(8'h00);
        check_rx(8'hFF);
        tick();

        // Start while busy is ignored
        accept(8'h81);
        check_frame(8'h81, 0, 1, 12);
        nd = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done1 === 1'b1) nd++;
            if (busy1 === 1'b1) nb++;
        end
        chk("ign_extra_done", nd, 0);
        chk("ign_not_queued", nb, 0);
        check_rx(8'h81);
        chk("ign_rx_extra", rx_q.size(), 0);

        // Abort with txEn low during data bit 3
        b = 8'($urandom);
        accept(b);
        repeat (17) tick();
        chk("abort_pre_tx", tx1, b[3]);
        chk("abort_pre_busy", busy1, 1);
        txEn = 1'b0;
        tick();
        chk("abort_tx", tx1, 1);
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        nd = 0;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            start1 = (i % 5 == 0);
            if (done1 === 1'b1) nd++;
            if (busy1 === 1'b1 || tx1 !== 1'b1) nb++;
            tick();
        end
        start1 = 1'b0;
        chk("abort_no_done", nd, 0);
        chk("disabled_ignores_start", nb, 0);
        txEn = 1'b1;
        tick();
        rx_q.delete();
        accept(8'h55);
        check_frame(8'h55, 0, 1, 0);
        check_rx(8'h55);
        tick();

        // Random 8N1 frames, some back-to-back
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            accept(b);
            check_frame(b, 0, 1, 0);
            check_rx(b);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        // Odd parity, two stop bits
        sel = 1'b1;
        accept(8'h07);
        check_frame(8'h07, 2, 2, 0);
        tick();
        chk("p2_done_once", done2, 0);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            accept(b);
            check_frame(b, 2, 2, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
